// File: rtl/png_adler32_chk_if.sv
// Stream/result bundle for the zlib Adler-32 trailer checker.
// err_cnt is only carried when PNG_ADLER32_CHK_ERR_CNT_EN is defined.
interface png_adler32_chk_if #(parameter int CNT_W = 8);
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_vld;
  logic        byte_last;
  logic        byte_rdy;
  logic [31:0] calc_adler;
  logic        chk_done;
  logic        chk_ok;
  logic        busy;
`ifdef PNG_ADLER32_CHK_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;

  modport master (output start, byte_in, byte_vld, byte_last,
                  input  byte_rdy, calc_adler, chk_done, chk_ok, busy, err_cnt);
  modport slave  (input  start, byte_in, byte_vld, byte_last,
                  output byte_rdy, calc_adler, chk_done, chk_ok, busy, err_cnt);
`else
  modport master (output start, byte_in, byte_vld, byte_last,
                  input  byte_rdy, calc_adler, chk_done, chk_ok, busy);
  modport slave  (input  start, byte_in, byte_vld, byte_last,
                  output byte_rdy, calc_adler, chk_done, chk_ok, busy);
`endif
endinterface

// File: rtl/png_adler32_chk.sv
// Adler-32 over a zlib payload, compared against the 4-byte MSB-first trailer.
// Optional saturating mismatch counter: define PNG_ADLER32_CHK_ERR_CNT_EN.
module png_adler32_chk #(
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  png_adler32_chk_if.slave bus
);
  localparam logic [16:0] MOD = 17'd65521;

  typedef enum logic [1:0] {IDLE, DATA, TRAILER, DONE} state_t;

  state_t      state_q;
  logic [15:0] s1_q, s2_q, s1_d, s2_d;
  logic [31:0] trl_q, trl_d;
  logic [1:0]  tcnt_q;
  logic        rdy_q, busy_q, done_q, ok_q;
  logic        acc;
  logic [16:0] sum1, sum2, dif1, dif2;

  assign acc = bus.byte_vld & rdy_q;

  // s1 < MOD and byte <= 255, so a single subtraction always lands in range
  always_comb begin
    sum1  = {1'b0, s1_q} + {9'd0, bus.byte_in};
    dif1  = sum1 - MOD;
    s1_d  = (sum1 >= MOD) ? dif1[15:0] : sum1[15:0];
    sum2  = {1'b0, s2_q} + {1'b0, s1_d};
    dif2  = sum2 - MOD;
    s2_d  = (sum2 >= MOD) ? dif2[15:0] : sum2[15:0];
    trl_d = {trl_q[23:0], bus.byte_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s1_q    <= 16'd1;
      s2_q    <= 16'd0;
      trl_q   <= '0;
      tcnt_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        // a byte offered alongside start is dropped: acc is ignored here
        state_q <= DATA;
        s1_q    <= 16'd1;
        s2_q    <= 16'd0;
        trl_q   <= '0;
        tcnt_q  <= '0;
        rdy_q   <= 1'b1;
        busy_q  <= 1'b1;
        ok_q    <= 1'b0;
      end else begin
        case (state_q)
          DATA: if (acc) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            if (bus.byte_last) state_q <= TRAILER;
          end
          TRAILER: if (acc) begin
            trl_q  <= trl_d;
            tcnt_q <= tcnt_q + 2'd1;
            if (tcnt_q == 2'd3) begin
              state_q <= DONE;
              rdy_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ok_q    <= (trl_d == {s2_q, s1_q});
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.byte_rdy   = rdy_q;
  assign bus.calc_adler = {s2_q, s1_q};
  assign bus.chk_done   = done_q;
  assign bus.chk_ok     = ok_q;
  assign bus.busy       = busy_q;

`ifdef PNG_ADLER32_CHK_ERR_CNT_EN
  logic [CNT_W-1:0] err_q;

  // survives start so it accumulates across streams
  always_ff @(posedge clk) begin
    if (rst)                                  err_q <= '0;
    else if (done_q && !ok_q && err_q != '1)  err_q <= err_q + 1'b1;
  end

  assign bus.err_cnt = err_q;
`endif
endmodule

// File: tb/tb_png_adler32_chk.sv
// Scoreboarded bench for png_adler32_chk: expected {adler, ok} queued per stream.
module tb_png_adler32_chk;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  png_adler32_chk_if #(.CNT_W(8)) ifc();
  png_adler32_chk #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct packed {logic [31:0] adl; logic ok;} exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_pass = 0, n_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] adl(input logic [7:0] d[$]);
    int unsigned a = 1, b = 0;
    foreach (d[i]) begin
      a = (a + d[i]) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  // scoreboard pop on every completion pulse
  always @(negedge clk) if (ifc.chk_done === 1'b1) begin
    exp_t e;
    n_done++;
    check("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_adler", ifc.calc_adler, e.adl);
      check("sb_ok", {31'd0, ifc.chk_ok}, {31'd0, e.ok});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_pulse(input logic vld, input logic [7:0] b);
    ifc.start = 1'b1; ifc.byte_vld = vld; ifc.byte_in = b;
    @(negedge clk);
    ifc.start = 1'b0; ifc.byte_vld = 1'b0;
  endtask

  task automatic put(input logic [7:0] b, input logic l, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    ifc.byte_in = b; ifc.byte_last = l; ifc.byte_vld = 1'b1;
    while (ifc.byte_rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("rdy_timeout", {31'd0, ifc.byte_rdy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    ifc.byte_vld = 1'b0; ifc.byte_last = 1'b0;
  endtask

  task automatic run_stream(input string tag, input logic [7:0] p[$],
                            input logic [31:0] trl, input bit gaps, input bit do_start);
    logic [7:0]  run[$];
    logic [31:0] e;
    int d0, n;
    e = adl(p);
    sb.push_back(exp_t'{adl: e, ok: (trl == e)});
    if (do_start) start_pulse(1'b0, 8'h00);
    foreach (p[i]) begin
      put(p[i], (i == p.size() - 1), gaps);
      run.push_back(p[i]);
      check({tag, "_run"}, ifc.calc_adler, adl(run));
    end
    d0 = n_done;
    for (int k = 0; k < 4; k++)
      put(trl[31-8*k -: 8], gaps ? 1'($urandom_range(0, 1)) : 1'b0, gaps);
    n = 0;
    while (n_done == d0 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, n_done - d0, 1);
    check({tag, "_ok_held"}, {31'd0, ifc.chk_ok}, {31'd0, (trl == e)});
    check({tag, "_rdy_done"}, {31'd0, ifc.byte_rdy}, 32'd0);
    check({tag, "_busy_done"}, {31'd0, ifc.busy}, 32'd0);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  logic [7:0] abc[$], wk[$], ff[$], xy[$];
  int d0;

  initial begin
    rst = 1'b1; ifc.start = 1'b0; ifc.byte_in = '0; ifc.byte_vld = 1'b0; ifc.byte_last = 1'b0;
    abc = '{8'h61, 8'h62, 8'h63};
    wk  = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    xy  = '{8'h78, 8'h79};
    for (int i = 0; i < 257; i++) ff.push_back(8'hFF);

    repeat (3) @(negedge clk);
    check("rst_adler", ifc.calc_adler, 32'h0000_0001);
    check("rst_rdy",   {31'd0, ifc.byte_rdy}, 32'd0);
    check("rst_busy",  {31'd0, ifc.busy},     32'd0);
    check("rst_done",  {31'd0, ifc.chk_done}, 32'd0);
    check("rst_ok",    {31'd0, ifc.chk_ok},   32'd0);
`ifdef PNG_ADLER32_CHK_ERR_CNT_EN
    check("rst_err", {24'd0, ifc.err_cnt}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_stream("abc", abc, 32'h024D_0127, 1'b0, 1'b1);
    check("abc_adler", ifc.calc_adler, 32'h024D_0127);

    run_stream("wiki", wk, 32'h11E6_0399, 1'b0, 1'b1);
    check("wiki_adler", ifc.calc_adler, 32'h11E6_0398);
    check("wiki_ok", {31'd0, ifc.chk_ok}, 32'd0);
`ifdef PNG_ADLER32_CHK_ERR_CNT_EN
    check("wiki_err", {24'd0, ifc.err_cnt}, 32'd1);
`endif

    run_stream("ff", ff, adl(ff), 1'b0, 1'b1);
    check("ff_s1", {16'd0, ifc.calc_adler[15:0]}, 32'h0000_000F);

    // abort two bytes into the trailer; byte offered with start must be dropped
    start_pulse(1'b0, 8'h00);
    put(xy[0], 1'b0, 1'b0);
    put(xy[1], 1'b1, 1'b0);
    put(8'h12, 1'b0, 1'b0);
    put(8'h34, 1'b0, 1'b0);
    d0 = n_done;
    start_pulse(1'b1, 8'h55);
    check("abort_adler", ifc.calc_adler, 32'h0000_0001);
    check("abort_busy",  {31'd0, ifc.busy},     32'd1);
    check("abort_rdy",   {31'd0, ifc.byte_rdy}, 32'd1);
    check("abort_ok",    {31'd0, ifc.chk_ok},   32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    run_stream("abc_after_abort", abc, 32'h024D_0127, 1'b0, 1'b0);

    // reset while a byte is in flight
    start_pulse(1'b0, 8'h00);
    put(8'h41, 1'b0, 1'b0);
    ifc.byte_in = 8'h11; ifc.byte_vld = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_adler", ifc.calc_adler, 32'h0000_0001);
    check("mrst_rdy",   {31'd0, ifc.byte_rdy}, 32'd0);
    check("mrst_busy",  {31'd0, ifc.busy},     32'd0);
    check("mrst_ok",    {31'd0, ifc.chk_ok},   32'd0);
`ifdef PNG_ADLER32_CHK_ERR_CNT_EN
    check("mrst_err", {24'd0, ifc.err_cnt}, 32'd0);
`endif
    @(negedge clk);
    check("idle_ignores", ifc.calc_adler, 32'h0000_0001);
    ifc.byte_vld = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 3; r++) run_stream("abc_gaps", abc, 32'h024D_0127, 1'b1, 1'b1);
    check("gaps_adler", ifc.calc_adler, 32'h024D_0127);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/png_adler32_chk.md
PNG_ADLER32_CHK -- requirements
Module: png_adler32_chk

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of mismatch counter; used only when PNG_ADLER32_CHK_ERR_CNT_EN is defined.
REQ-002 The block SHALL have port clk  input  1  global clock, all logic on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port start  input  1  begin new zlib stream check, single-cycle pulse.
REQ-005 The block SHALL have port byte_in  input  8  stream byte: payload, then 4 trailer bytes, MSB first.
REQ-006 The block SHALL have port byte_vld  input  1  byte_in valid.
REQ-007 The block SHALL have port byte_last  input  1  qualifies byte_in as last payload byte; ignored on trailer bytes.
REQ-008 The block SHALL have port byte_rdy  output  1  block accepts byte; transfer = byte_vld & byte_rdy.
REQ-009 The block SHALL have port calc_adler  output  32  running checksum {s2,s1}.
REQ-010 The block SHALL have port chk_done  output  1  one-cycle pulse, compare complete.
REQ-011 The block SHALL have port chk_ok  output  1  1 = trailer equals calc_adler; valid from chk_done until next start/rst.
REQ-012 The block SHALL have port busy  output  1  high in DATA or TRAILER.
REQ-013 The block SHALL have port err_cnt  output  CNT_W  saturating mismatch count; present only with PNG_ADLER32_CHK_ERR_CNT_EN.

Function
REQ-014 The FSM SHALL have states IDLE, DATA, TRAILER, DONE.
REQ-015 IDLE/DONE -> DATA on start; DATA -> TRAILER on accepted byte with byte_last; TRAILER -> DONE on 4th accepted trailer byte; DONE holds until start.
REQ-016 start in any state SHALL set calc_adler to 32'h0000_0001, clear trailer shift register and byte count, clear chk_ok, enter DATA.
REQ-017 byte_rdy SHALL be a registered output, 1 in DATA and TRAILER, 0 in IDLE and DONE; a byte presented in the same cycle as start SHALL be discarded.
REQ-018 On each accepted payload byte (including the last), s1 SHALL become (s1+byte_in) mod 65521 and s2 SHALL become (s2+new s1) mod 65521, each via one conditional subtraction of 65521 on a 17-bit sum; calc_adler SHALL update on the next clock edge (1-cycle latency).
REQ-019 Trailer bytes SHALL NOT update calc_adler; they SHALL shift into a 32-bit register, first byte ending in bits [31:24].
REQ-020 chk_done SHALL pulse for exactly one cycle, on the cycle after the 4th trailer byte is accepted; chk_ok SHALL be driven the same cycle and held through DONE.
REQ-021 A payload of at least one byte SHALL be required; byte_last on a trailer byte SHALL have no effect.
REQ-022 Bytes with byte_vld low SHALL leave all state unchanged; gaps of any length SHALL be tolerated.

Reset
REQ-023 On rst=1 at a rising edge: state IDLE, calc_adler=32'h0000_0001, byte_rdy=0, chk_done=0, chk_ok=0, busy=0, err_cnt=0; rst SHALL override start and any in-flight byte.

Configuration
REQ-024 With PNG_ADLER32_CHK_ERR_CNT_EN defined, the err_cnt port SHALL exist and increment by 1 on each chk_done with chk_ok=0, saturating at all-ones, cleared only by rst (not by start).
REQ-025 Without PNG_ADLER32_CHK_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 The bench SHALL check: start, payload "abc" (last on 'c'), trailer 02 4D 01 27 -> calc_adler=0x024D0127, chk_done one pulse, chk_ok=1.
REQ-027 The bench SHALL check: payload "Wikipedia", trailer 11 E6 03 99 -> calc_adler=0x11E60398, chk_ok=0, err_cnt=1 (macro on).
REQ-028 The bench SHALL check: 257 bytes of 0xFF -> s1 wraps, calc_adler[15:0]=0x000F; a matching trailer from the software model -> chk_ok=1.
REQ-029 The bench SHALL check: start asserted after 2 trailer bytes of a stream -> calc_adler=1, no chk_done; the new stream "abc" then passes.
REQ-030 The bench SHALL check: rst mid-DATA with byte_vld=1 -> next cycle IDLE, byte_rdy=0, calc_adler=1, err_cnt=0.
REQ-031 The bench SHALL check: random byte_vld gaps on "abc" -> same result as REQ-026; chk_done single pulse.
